// File: rtl/core_pkg.sv
// Core-wide decoded instruction types shared between decode and the back end.
package core_pkg;

   typedef struct packed {
      logic [1:0] instruction_type;
      logic [3:0] alu_op;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       illegal;
   } control_signal_bus;

endpackage

// File: rtl/dispatch_pkg.sv
// Dispatch-stage constants: reservation-station type codes and the slot FSM state.
package dispatch_pkg;

   localparam logic [1:0] ITYPE_ALU    = 2'b00;
   localparam logic [1:0] ITYPE_BRANCH = 2'b01;
   localparam logic [1:0] ITYPE_LOAD   = 2'b10;
   localparam logic [1:0] ITYPE_STORE  = 2'b11;

   typedef enum logic {ST_EMPTY, ST_HELD} dispatch_state_t;

   function automatic logic [3:0] station_onehot(input logic [1:0] itype);
      return 4'b0001 << itype;
   endfunction

endpackage

// File: rtl/dispatch_stat_counter.sv
// 32-bit saturating event counter with synchronous clear and a parallel load.
module dispatch_stat_counter (
   input  logic        clk,
   input  logic        clear,
   input  logic        load,
   input  logic [31:0] load_value,
   input  logic        inc,
   output logic [31:0] count
);

   always_ff @(posedge clk) begin
      if (clear)
         count <= '0;
      else if (load)
         count <= load_value;
      else if (inc && (count != 32'hFFFF_FFFF))
         count <= count + 32'd1;
   end

endmodule

// File: rtl/dispatch_controller.sv
// Single-slot dispatch stage: holds one decoded instruction, allocates a ROB entry and
// strobes the reservation station chosen by its type. Optional stats: DISPATCH_STATS_EN.
module dispatch_controller
   import core_pkg::*;
   import dispatch_pkg::*;
#(
   parameter int XLEN          = 32,
   parameter int ROB_TAG_WIDTH = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     instruction_valid,
   output logic                     instruction_ready,
   input  logic [XLEN-1:0]          immediate,
   input  logic [XLEN-1:0]          pc,
   input  control_signal_bus        control_signals,
   input  logic                     flush,
   input  logic                     rob_full,
   input  logic [ROB_TAG_WIDTH-1:0] rob_tail_tag,
   output logic                     rob_alloc,
   input  logic [3:0]               rs_full,
   output logic [3:0]               rs_dispatch,
   output logic [XLEN-1:0]          dispatch_immediate,
   output logic [XLEN-1:0]          dispatch_pc,
   output control_signal_bus        dispatch_control,
   output logic [ROB_TAG_WIDTH-1:0] dispatch_rob_tag
`ifdef DISPATCH_STATS_EN
   ,
   output logic [31:0]              stall_rob_cycles,
   output logic [31:0]              stall_rs_cycles,
   output logic [31:0]              dispatched_count
`endif
);

   dispatch_state_t state, state_nxt;
   logic            hold_valid;
   logic [1:0]      held_type;
   logic            fire;
   logic            accept;

   assign hold_valid = (state == ST_HELD);
   assign held_type  = dispatch_control.instruction_type;

   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_EMPTY;
      else
         state <= state_nxt;
   end

   // Flush outranks everything: it masks both fire and accept before they reach the FSM.
   always_comb begin
      state_nxt         = state;
      fire              = 1'b0;
      instruction_ready = 1'b0;
      accept            = 1'b0;
      rob_alloc         = 1'b0;
      rs_dispatch       = 4'b0000;
      dispatch_rob_tag  = '0;

      fire              = hold_valid && !flush && !rob_full && !rs_full[held_type];
      instruction_ready = !flush && (!hold_valid || fire);
      accept            = instruction_valid && instruction_ready;

      if (fire) begin
         rob_alloc        = 1'b1;
         rs_dispatch      = station_onehot(held_type);
         dispatch_rob_tag = rob_tail_tag;
      end

      if (flush)
         state_nxt = ST_EMPTY;
      else if (accept)
         state_nxt = ST_HELD;
      else if (fire)
         state_nxt = ST_EMPTY;
   end

   // Slot data is only written on accept; when EMPTY it is stale but strobes are gated.
   always_ff @(posedge clk) begin
      if (reset) begin
         dispatch_immediate <= '0;
         dispatch_pc        <= '0;
         dispatch_control   <= '0;
      end else if (accept) begin
         dispatch_immediate <= immediate;
         dispatch_pc        <= pc;
         dispatch_control   <= control_signals;
      end
   end

`ifdef DISPATCH_STATS_EN
   logic stall;

   assign stall = hold_valid && !flush && !fire;

   dispatch_stat_counter u_stall_rob (
      .clk(clk), .clear(reset), .load(1'b0), .load_value(32'd0),
      .inc(stall && rob_full), .count(stall_rob_cycles)
   );

   dispatch_stat_counter u_stall_rs (
      .clk(clk), .clear(reset), .load(1'b0), .load_value(32'd0),
      .inc(stall && !rob_full), .count(stall_rs_cycles)
   );

   dispatch_stat_counter u_dispatched (
      .clk(clk), .clear(reset), .load(1'b0), .load_value(32'd0),
      .inc(fire), .count(dispatched_count)
   );
`endif

endmodule

// File: tb/tb_dispatch_controller.sv
// Directed table-driven bench for dispatch_controller; one row per clock cycle.
module tb_dispatch_controller;
   import core_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic              instruction_valid;
   logic              instruction_ready;
   logic [31:0]       immediate;
   logic [31:0]       pc;
   control_signal_bus control_signals;
   logic              flush;
   logic              rob_full;
   logic [2:0]        rob_tail_tag;
   logic              rob_alloc;
   logic [3:0]        rs_full;
   logic [3:0]        rs_dispatch;
   logic [31:0]       dispatch_immediate;
   logic [31:0]       dispatch_pc;
   control_signal_bus dispatch_control;
   logic [2:0]        dispatch_rob_tag;
`ifdef DISPATCH_STATS_EN
   logic [31:0]       stall_rob_cycles;
   logic [31:0]       stall_rs_cycles;
   logic [31:0]       dispatched_count;
   logic              sat_clear, sat_load, sat_inc;
   logic [31:0]       sat_val, sat_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dispatch_controller #(.XLEN(32), .ROB_TAG_WIDTH(3)) dut (
      .clk(clk), .reset(reset),
      .instruction_valid(instruction_valid), .instruction_ready(instruction_ready),
      .immediate(immediate), .pc(pc), .control_signals(control_signals),
      .flush(flush), .rob_full(rob_full), .rob_tail_tag(rob_tail_tag),
      .rob_alloc(rob_alloc), .rs_full(rs_full), .rs_dispatch(rs_dispatch),
      .dispatch_immediate(dispatch_immediate), .dispatch_pc(dispatch_pc),
      .dispatch_control(dispatch_control), .dispatch_rob_tag(dispatch_rob_tag)
`ifdef DISPATCH_STATS_EN
      , .stall_rob_cycles(stall_rob_cycles), .stall_rs_cycles(stall_rs_cycles),
      .dispatched_count(dispatched_count)
`endif
   );

`ifdef DISPATCH_STATS_EN
   dispatch_stat_counter u_sat (
      .clk(clk), .clear(sat_clear), .load(sat_load), .load_value(sat_val),
      .inc(sat_inc), .count(sat_cnt)
   );
`endif

   typedef struct {
      logic        rst, vld;
      logic [1:0]  typ;
      logic [31:0] imm;
      logic        fl, robf;
      logic [2:0]  tag;
      logic [3:0]  rsf;
      logic        chk, rdy, alloc;
      logic [3:0]  disp;
      logic [2:0]  etag;
      logic        chkd;
      logic [31:0] eimm;
   } vec_t;

   localparam int NV = 28;
   vec_t vt [NV];

   function automatic vec_t mk(int rst, int vld, int typ, int imm, int fl, int robf,
                               int tag, int rsf, int chk, int rdy, int alloc, int disp,
                               int etag, int chkd, int eimm);
      vec_t r;
      r.rst = rst[0];  r.vld = vld[0];  r.typ = typ[1:0];  r.imm = imm;
      r.fl = fl[0];    r.robf = robf[0]; r.tag = tag[2:0]; r.rsf = rsf[3:0];
      r.chk = chk[0];  r.rdy = rdy[0];  r.alloc = alloc[0]; r.disp = disp[3:0];
      r.etag = etag[2:0]; r.chkd = chkd[0]; r.eimm = eimm;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t r);
      reset                            = r.rst;
      instruction_valid                = r.vld;
      immediate                        = r.imm;
      pc                               = r.imm + 32'h1000;
      control_signals                  = '0;
      control_signals.instruction_type = r.typ;
      control_signals.rd               = r.imm[4:0];
      flush                            = r.fl;
      rob_full                         = r.robf;
      rob_tail_tag                     = r.tag;
      rs_full                          = r.rsf;
   endtask

   initial begin
      //          rst vld typ imm   fl rf tag rsf      chk rdy al disp     et chkd eimm
      vt[0]  = mk(1, 0, 0, 0,     0, 0, 0, 0,       0, 0, 0, 0,       0, 0, 0);
      vt[1]  = mk(0, 0, 0, 0,     0, 0, 0, 0,       1, 1, 0, 0,       0, 1, 0);
      vt[2]  = mk(0, 1, 0, 'h10,  0, 0, 0, 0,       1, 1, 0, 0,       0, 0, 0);
      vt[3]  = mk(0, 1, 0, 'h11,  0, 0, 0, 0,       1, 1, 1, 'b0001,  0, 1, 'h10);
      vt[4]  = mk(0, 1, 0, 'h12,  0, 0, 1, 0,       1, 1, 1, 'b0001,  1, 1, 'h11);
      vt[5]  = mk(0, 1, 0, 'h13,  0, 0, 2, 0,       1, 1, 1, 'b0001,  2, 1, 'h12);
      vt[6]  = mk(0, 0, 0, 0,     0, 0, 3, 0,       1, 1, 1, 'b0001,  3, 1, 'h13);
      vt[7]  = mk(0, 1, 2, 'h20,  0, 0, 0, 'b0100,  1, 1, 0, 0,       0, 0, 0);
      vt[8]  = mk(0, 1, 0, 'h99,  0, 0, 0, 'b0100,  1, 0, 0, 0,       0, 0, 0);
      vt[9]  = mk(0, 1, 0, 'h99,  0, 0, 0, 'b0100,  1, 0, 0, 0,       0, 0, 0);
      vt[10] = mk(0, 1, 0, 'h99,  0, 0, 0, 'b0100,  1, 0, 0, 0,       0, 0, 0);
      vt[11] = mk(0, 0, 0, 0,     0, 0, 5, 0,       1, 1, 1, 'b0100,  5, 1, 'h20);
      vt[12] = mk(0, 1, 2, 'h21,  0, 0, 0, 'b0010,  1, 1, 0, 0,       0, 0, 0);
      vt[13] = mk(0, 0, 0, 0,     0, 0, 6, 'b0010,  1, 1, 1, 'b0100,  6, 1, 'h21);
      vt[14] = mk(0, 1, 3, 'h30,  0, 0, 0, 0,       1, 1, 0, 0,       0, 0, 0);
      vt[15] = mk(0, 0, 0, 0,     0, 1, 0, 0,       1, 0, 0, 0,       0, 0, 0);
      vt[16] = mk(0, 0, 0, 0,     0, 1, 0, 0,       1, 0, 0, 0,       0, 0, 0);
      vt[17] = mk(0, 0, 0, 0,     0, 0, 7, 0,       1, 1, 1, 'b1000,  7, 1, 'h30);
      vt[18] = mk(0, 1, 1, 'h40,  0, 0, 0, 0,       1, 1, 0, 0,       0, 0, 0);
      vt[19] = mk(0, 1, 0, 'h41,  1, 0, 0, 'b0010,  1, 0, 0, 0,       0, 0, 0);
      vt[20] = mk(0, 0, 0, 0,     0, 0, 0, 0,       1, 1, 0, 0,       0, 1, 'h40);
      vt[21] = mk(0, 1, 1, 'h50,  0, 0, 0, 0,       1, 1, 0, 0,       0, 0, 0);
      vt[22] = mk(0, 0, 0, 0,     0, 0, 0, 'b0010,  1, 0, 0, 0,       0, 0, 0);
      vt[23] = mk(1, 0, 0, 0,     0, 0, 0, 'b0010,  1, 0, 0, 0,       0, 0, 0);
      vt[24] = mk(0, 0, 0, 0,     0, 0, 0, 0,       1, 1, 0, 0,       0, 1, 0);
      vt[25] = mk(0, 1, 1, 'h60,  0, 0, 0, 0,       1, 1, 0, 0,       0, 0, 0);
      vt[26] = mk(0, 0, 0, 0,     0, 0, 2, 0,       1, 1, 1, 'b0010,  2, 1, 'h60);
      vt[27] = mk(0, 0, 0, 0,     0, 0, 0, 0,       1, 1, 0, 0,       0, 0, 0);

`ifdef DISPATCH_STATS_EN
      sat_clear = 1'b1; sat_load = 1'b0; sat_inc = 1'b0; sat_val = 32'd0;
`endif
      drive(vt[0]);
      for (int i = 0; i < NV; i++) begin
         drive(vt[i]);
         @(negedge clk);
         if (vt[i].chk) begin
            check($sformatf("row%0d ready", i), {31'd0, instruction_ready}, {31'd0, vt[i].rdy});
            check($sformatf("row%0d rob_alloc", i), {31'd0, rob_alloc}, {31'd0, vt[i].alloc});
            check($sformatf("row%0d rs_dispatch", i), {28'd0, rs_dispatch}, {28'd0, vt[i].disp});
            check($sformatf("row%0d rob_tag", i), {29'd0, dispatch_rob_tag}, {29'd0, vt[i].etag});
         end
         if (vt[i].chkd) begin
            check($sformatf("row%0d imm", i), dispatch_immediate, vt[i].eimm);
            check($sformatf("row%0d pc", i), dispatch_pc,
                  (vt[i].eimm == 32'd0) ? 32'd0 : vt[i].eimm + 32'h1000);
            check($sformatf("row%0d ctrl_rd", i), {27'd0, dispatch_control.rd},
                  {27'd0, vt[i].eimm[4:0]});
         end
`ifdef DISPATCH_STATS_EN
         if (i == 18) begin
            check("stall_rob_mid", stall_rob_cycles, 32'd2);
            check("stall_rs_mid", stall_rs_cycles, 32'd3);
            check("dispatched_mid", dispatched_count, 32'd7);
         end
         if (i == 27) begin
            check("stall_rob_after_rst", stall_rob_cycles, 32'd0);
            check("stall_rs_after_rst", stall_rs_cycles, 32'd0);
            check("dispatched_after_rst", dispatched_count, 32'd1);
         end
`endif
         @(posedge clk);
         #1;
      end

`ifdef DISPATCH_STATS_EN
      sat_clear = 1'b0; sat_load = 1'b1; sat_val = 32'hFFFF_FFFE;
      @(posedge clk); #1;
      sat_load = 1'b0; sat_inc = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      sat_inc = 1'b0;
      @(negedge clk);
      check("saturation", sat_cnt, 32'hFFFF_FFFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dispatch_controller.md
# dispatch_controller

Sequences decoded instructions from the instruction decode stage into the out-of-order back end. Holds one decoded instruction (immediate, control signal bus, PC) in a registered dispatch slot, allocates a reorder buffer entry, and steers it to the reservation station selected by the decoded instruction type. It stalls when the ROB or the target station is full, and discards the held instruction on a pipeline flush.

## Interface
- XLEN, 32, datapath width of immediate and PC
- ROB_TAG_WIDTH, 3, width of ROB entry tag (ROB depth 2**ROB_TAG_WIDTH)

- clk  in  1  clock; one clock domain, all state on rising edge
- reset  in  1  synchronous, active-high reset
- instruction_valid  in  1  decode presents an instruction this cycle
- instruction_ready  out  1  controller accepts it at this edge
- immediate  in  XLEN  decoded immediate
- pc  in  XLEN  PC of the decoded instruction
- control_signals  in  control_signal_bus  decoded control bus (instruction_type field used for steering)
- flush  in  1  mispredict/exception flush; kills held instruction
- rob_full  in  1  ROB cannot allocate this cycle
- rob_tail_tag  in  ROB_TAG_WIDTH  tag the ROB will assign on allocation
- rob_alloc  out  1  allocate ROB entry this cycle
- rs_full  in  4  per-station full: [0] ALU, [1] branch, [2] load, [3] store
- rs_dispatch  out  4  one-hot write strobe to the selected station
- dispatch_immediate  out  XLEN  held immediate
- dispatch_pc  out  XLEN  held PC
- dispatch_control  out  control_signal_bus  held control bus
- dispatch_rob_tag  out  ROB_TAG_WIDTH  equals rob_tail_tag while dispatching

## Operation
- States: EMPTY (slot invalid), HELD (slot valid). Slot registers: immediate, pc, control, hold_valid.
- accept = instruction_valid && instruction_ready; instruction_ready = !flush && (state==EMPTY || fire).
- fire = state==HELD && !flush && !rob_full && !rs_full[type], type = held control.instruction_type.
- On fire: rob_alloc=1, rs_dispatch = 1<<type, dispatch_rob_tag = rob_tail_tag (combinational pass-through). Otherwise rob_alloc=0, rs_dispatch=0.
- Transitions: EMPTY+accept -> HELD; HELD+fire+accept -> HELD (slot reloaded); HELD+fire+!accept -> EMPTY; HELD+!fire -> HELD (stall, slot unchanged); any state+flush -> EMPTY.
- Flush has priority over everything: no fire, no accept, slot invalidated at the edge.
- Slot data registers load only on accept; they hold stale data when EMPTY (don't-care, but strobes are 0).
- Illegal opcodes decode to instruction_type ALU and dispatch to the ALU station unchanged.

## Timing
- Reset: state EMPTY; rob_alloc=0; rs_dispatch=0; dispatch_immediate, dispatch_pc, dispatch_control, and all stats counters cleared to 0. instruction_ready=1 in the first cycle after reset deasserts (if flush=0).
- Latency: accepted at edge N -> strobes high in cycle N+1 at earliest.
- Throughput: 1 instruction/cycle with no stalls (fire and accept in the same cycle).
- Stall release: strobes assert in the same cycle rob_full/rs_full deassert (combinational from those inputs).
- A full signal on a non-target station never stalls.
- Reset mid-stall: held instruction dropped, no strobe is issued.

## Configuration
- DISPATCH_STATS_EN defined: adds outputs stall_rob_cycles, stall_rs_cycles, dispatched_count (32 bits each, saturating at all-ones). A stall cycle is HELD && !flush && !fire. Count it as stall_rob when rob_full=1; otherwise count it as stall_rs. dispatched_count increments on fire. Counters clear on reset, not on flush.
- Undefined: these ports and counters are absent; the rest of the behaviour is identical.

## Structure
- Shared package: instruction type constants (ALU=2'b00, BRANCH=2'b01, LOAD=2'b10, STORE=2'b11), dispatch state enum. control_signal_bus stays in its existing package.
- One sub-module under DISPATCH_STATS_EN: dispatch_stat_counter (32-bit saturating, increment and synchronous clear), instantiated three times.

## Test plan
- Back-to-back: 4 ALU instructions, valid every cycle, no fulls, rob_tail_tag 0..3 -> rs_dispatch=0001 in cycles 1–4 with tags 0..3, and instruction_ready stays 1.
- Station steering: type 2 held with rs_full=0100 for 3 cycles -> no strobes and ready=0 for 3 cycles, then rs_dispatch=0100. Repeat with rs_full=0010 and a held load -> dispatches immediately.
- ROB full: rob_full=1 for 2 cycles with a store held -> rob_alloc=0, then rob_alloc=1 and rs_dispatch=1000. With DISPATCH_STATS_EN, stall_rob_cycles=2.
- Flush while HELD and stalled, with instruction_valid=1 -> no strobes, ready=0 that cycle, state EMPTY next cycle, and the flushed-cycle instruction is not captured.
- Reset asserted mid-stall -> all outputs 0 the next cycle; after release, a new branch dispatches with rs_dispatch=0010.
- Saturation (stats build): preload the counter to 32'hFFFF_FFFE and apply 3 stall cycles -> the counter reads 32'hFFFF_FFFF.
